// File: rtl/ekf_stage_seq.sv
// Stage sequencer for the EKF-SLAM accelerator: runs one or more RSA passes
// per one-hot stage request, each followed by a nonlinear-unit handshake.
module ekf_stage_seq #(
    parameter int STAGE_NUM  = 3,
    parameter int ROW_LEN    = 10,
    parameter int SEQ_CNT_DW = 5,
    parameter int TO_DW      = 16,
    parameter int TO_CYC     = 1000
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic [ROW_LEN-1:0]    landmark_num,
    input  logic [STAGE_NUM-1:0]  stage_val,
    output logic [STAGE_NUM-1:0]  stage_rdy,
    output logic [STAGE_NUM-1:0]  stage_done,
    output logic                  stage_err,
    output logic                  rsa_start,
    output logic [STAGE_NUM-1:0]  rsa_mode,
    input  logic                  rsa_done,
    output logic [SEQ_CNT_DW-1:0] seq_idx,
    output logic [STAGE_NUM-1:0]  nonlinear_m_val,
    input  logic [STAGE_NUM-1:0]  nonlinear_s_rdy,
    output logic [STAGE_NUM-1:0]  nonlinear_m_rdy,
    input  logic [STAGE_NUM-1:0]  nonlinear_s_val
);

    localparam int UPD_BIT  = 2;
    localparam int PASS_MAX = (1 << SEQ_CNT_DW) - 1;
    localparam int LW       = (ROW_LEN > SEQ_CNT_DW) ? ROW_LEN : SEQ_CNT_DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_CALC,
        S_NL_REQ,
        S_NL_RSP,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [STAGE_NUM-1:0]  mode_n;
    logic [SEQ_CNT_DW-1:0] idx_n;
    logic [SEQ_CNT_DW-1:0] pass_total;
    logic [SEQ_CNT_DW-1:0] total_n;
    logic [SEQ_CNT_DW-1:0] upd_total;
    logic [SEQ_CNT_DW:0]   idx_next;
    logic [LW-1:0]         lm_w;
    logic [TO_DW-1:0]      wd_cnt;
    logic                  err_n;
    logic                  req_onehot;
    logic                  counting;
    logic                  wd_hit;

    always_comb begin
        req_onehot = (stage_val != '0) &&
                     ((stage_val & (stage_val - STAGE_NUM'(1))) == '0);
        lm_w       = LW'(landmark_num);
        upd_total  = (lm_w > LW'(PASS_MAX)) ? SEQ_CNT_DW'(PASS_MAX)
                                            : SEQ_CNT_DW'(lm_w);
        idx_next   = {1'b0, seq_idx} + {{SEQ_CNT_DW{1'b0}}, 1'b1};
        counting   = (state == S_CALC) || (state == S_NL_REQ) ||
                     (state == S_NL_RSP);
        wd_hit     = (TO_CYC != 0) && counting &&
                     (wd_cnt == TO_DW'(TO_CYC - 1));
    end

    always_comb begin
        state_n = state;
        mode_n  = rsa_mode;
        idx_n   = seq_idx;
        total_n = pass_total;
        err_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_onehot) begin
                    if (stage_val[UPD_BIT] && landmark_num == '0) begin
                        err_n = 1'b1;
                    end else begin
                        mode_n  = stage_val;
                        idx_n   = '0;
                        total_n = stage_val[UPD_BIT] ? upd_total
                                                     : SEQ_CNT_DW'(1);
                        state_n = S_LAUNCH;
                    end
                end else if (stage_val != '0) begin
                    err_n = 1'b1;
                end
            end
            S_LAUNCH: state_n = S_CALC;
            S_CALC: begin
                if (rsa_done) state_n = S_NL_REQ;
            end
            S_NL_REQ: begin
                if ((nonlinear_s_rdy & rsa_mode) != '0) state_n = S_NL_RSP;
            end
            S_NL_RSP: begin
                if ((nonlinear_s_val & rsa_mode) != '0) begin
                    if (idx_next < {1'b0, pass_total}) begin
                        idx_n   = idx_next[SEQ_CNT_DW-1:0];
                        state_n = S_LAUNCH;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                mode_n  = '0;
                state_n = S_IDLE;
            end
            default: begin
                mode_n  = '0;
                state_n = S_IDLE;
            end
        endcase
        // A handshake landing on the timeout edge still wins.
        if (wd_hit && state_n == state) begin
            err_n   = 1'b1;
            mode_n  = '0;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state           <= S_IDLE;
            rsa_mode        <= '0;
            seq_idx         <= '0;
            pass_total      <= '0;
            wd_cnt          <= '0;
            stage_rdy       <= '1;
            stage_done      <= '0;
            stage_err       <= 1'b0;
            rsa_start       <= 1'b0;
            nonlinear_m_val <= '0;
            nonlinear_m_rdy <= '0;
        end else begin
            state      <= state_n;
            rsa_mode   <= mode_n;
            seq_idx    <= idx_n;
            pass_total <= total_n;
            if (state_n != state)
                wd_cnt <= '0;
            else if (counting && wd_cnt != '1)
                wd_cnt <= wd_cnt + TO_DW'(1);
            stage_rdy       <= (state_n == S_IDLE) ? '1 : '0;
            stage_done      <= (state_n == S_DONE) ? rsa_mode : '0;
            stage_err       <= err_n;
            rsa_start       <= (state_n == S_LAUNCH);
            nonlinear_m_val <= (state_n == S_NL_REQ) ? mode_n : '0;
            nonlinear_m_rdy <= (state_n == S_NL_RSP) ? mode_n : '0;
        end
    end

endmodule

// File: tb/tb_ekf_stage_seq.sv
// Directed bench for ekf_stage_seq: single-pass, multi-pass, illegal
// requests, foreign-stage handshakes, watchdog and mid-stage reset.
module tb_ekf_stage_seq;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic [9:0] landmark_num;
    logic [2:0] stage_val;
    logic [2:0] stage_rdy;
    logic [2:0] stage_done;
    logic       stage_err;
    logic       rsa_start;
    logic [2:0] rsa_mode;
    logic       rsa_done;
    logic [4:0] seq_idx;
    logic [2:0] nonlinear_m_val;
    logic [2:0] nonlinear_s_rdy;
    logic [2:0] nonlinear_m_rdy;
    logic [2:0] nonlinear_s_val;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int n_done   = 0;
    int n_err    = 0;
    int s_start;
    int s_done;
    int s_err;

    ekf_stage_seq #(
        .STAGE_NUM (3),
        .ROW_LEN   (10),
        .SEQ_CNT_DW(5),
        .TO_DW     (16),
        .TO_CYC    (20)
    ) dut (
        .clk            (clk),
        .sys_rst        (sys_rst),
        .landmark_num   (landmark_num),
        .stage_val      (stage_val),
        .stage_rdy      (stage_rdy),
        .stage_done     (stage_done),
        .stage_err      (stage_err),
        .rsa_start      (rsa_start),
        .rsa_mode       (rsa_mode),
        .rsa_done       (rsa_done),
        .seq_idx        (seq_idx),
        .nonlinear_m_val(nonlinear_m_val),
        .nonlinear_s_rdy(nonlinear_s_rdy),
        .nonlinear_m_rdy(nonlinear_m_rdy),
        .nonlinear_s_val(nonlinear_s_val)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsa_start) n_start++;
        if (stage_done != 3'b000) n_done++;
        if (stage_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!rsa_start && n < 64) begin
            tick();
            n++;
        end
        chk(tag, 32'(rsa_start), 32'd1);
    endtask

    task automatic wait_mval(input string tag);
        int n = 0;
        while (nonlinear_m_val == 3'b000 && n < 64) begin
            tick();
            n++;
        end
        chk(tag, 32'(nonlinear_m_val), 32'd4);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},  32'(stage_rdy), 32'd7);
        chk({tag, "_done"}, 32'(stage_done), 32'd0);
        chk({tag, "_err"},  32'(stage_err), 32'd0);
        chk({tag, "_start"}, 32'(rsa_start), 32'd0);
        chk({tag, "_mode"}, 32'(rsa_mode), 32'd0);
        chk({tag, "_idx"},  32'(seq_idx), 32'd0);
        chk({tag, "_mval"}, 32'(nonlinear_m_val), 32'd0);
        chk({tag, "_mrdy"}, 32'(nonlinear_m_rdy), 32'd0);
    endtask

    task automatic idle_inputs();
        stage_val       = 3'b000;
        rsa_done        = 1'b0;
        nonlinear_s_rdy = 3'b000;
        nonlinear_s_val = 3'b000;
    endtask

    task automatic run_prd_0wait(input string tag);
        s_start         = n_start;
        rsa_done        = 1'b1;
        nonlinear_s_rdy = 3'b001;
        nonlinear_s_val = 3'b001;
        stage_val       = 3'b001;
        tick();
        stage_val = 3'b000;
        chk({tag, "_start"}, 32'(rsa_start), 32'd1);
        chk({tag, "_rdy_busy"}, 32'(stage_rdy), 32'd0);
        chk({tag, "_mode"}, 32'(rsa_mode), 32'd1);
        tick();
        tick();
        chk({tag, "_mval"}, 32'(nonlinear_m_val), 32'd1);
        tick();
        chk({tag, "_mrdy"}, 32'(nonlinear_m_rdy), 32'd1);
        tick();
        chk({tag, "_done"}, 32'(stage_done), 32'd1);
        tick();
        chk({tag, "_done_low"}, 32'(stage_done), 32'd0);
        chk({tag, "_rdy_idle"}, 32'(stage_rdy), 32'd7);
        chk({tag, "_nstart"}, 32'(n_start - s_start), 32'd1);
        idle_inputs();
    endtask

    initial begin
        sys_rst      = 1'b1;
        landmark_num = 10'd0;
        idle_inputs();
        tick();
        tick();
        chk_reset_outputs("reset");
        sys_rst = 1'b0;
        tick();

        run_prd_0wait("prd");

        s_start   = n_start;
        stage_val = 3'b011;
        tick();
        stage_val = 3'b000;
        chk("multi_err", 32'(stage_err), 32'd1);
        chk("multi_rdy", 32'(stage_rdy), 32'd7);
        tick();
        chk("multi_err_low", 32'(stage_err), 32'd0);

        landmark_num = 10'd0;
        stage_val    = 3'b100;
        tick();
        stage_val = 3'b000;
        chk("upd0_err", 32'(stage_err), 32'd1);
        tick();
        chk("upd0_err_low", 32'(stage_err), 32'd0);
        chk("illegal_nstart", 32'(n_start - s_start), 32'd0);

        s_start      = n_start;
        s_done       = n_done;
        landmark_num = 10'd6;
        stage_val    = 3'b100;
        tick();
        stage_val    = 3'b000;
        landmark_num = 10'd9;
        for (int p = 0; p < 6; p++) begin
            wait_start($sformatf("upd_start%0d", p));
            chk($sformatf("upd_idx%0d", p), 32'(seq_idx), 32'(p));
            tick();
            tick();
            rsa_done = 1'b1;
            tick();
            rsa_done = 1'b0;
            wait_mval($sformatf("upd_mval%0d", p));
            repeat (5) tick();
            chk($sformatf("upd_mval_hold%0d", p),
                32'(nonlinear_m_val), 32'd4);
            nonlinear_s_rdy = 3'b100;
            tick();
            nonlinear_s_rdy = 3'b000;
            chk($sformatf("upd_mrdy%0d", p), 32'(nonlinear_m_rdy), 32'd4);
            repeat (10) tick();
            nonlinear_s_val = 3'b100;
            tick();
            nonlinear_s_val = 3'b000;
        end
        chk("upd_done", 32'(stage_done), 32'd4);
        tick();
        chk("upd_rdy", 32'(stage_rdy), 32'd7);
        chk("upd_nstart", 32'(n_start - s_start), 32'd6);
        chk("upd_ndone", 32'(n_done - s_done), 32'd1);

        stage_val = 3'b010;
        tick();
        stage_val = 3'b000;
        rsa_done  = 1'b1;
        tick();
        tick();
        rsa_done = 1'b0;
        chk("ws_mval", 32'(nonlinear_m_val), 32'd2);
        nonlinear_s_rdy = 3'b100;
        repeat (3) tick();
        chk("ws_mval_hold", 32'(nonlinear_m_val), 32'd2);
        chk("ws_no_xfer", 32'(nonlinear_m_rdy), 32'd0);
        nonlinear_s_rdy = 3'b010;
        tick();
        nonlinear_s_rdy = 3'b000;
        chk("ws_mval_drop", 32'(nonlinear_m_val), 32'd0);
        chk("ws_mrdy", 32'(nonlinear_m_rdy), 32'd2);
        nonlinear_s_val = 3'b010;
        tick();
        nonlinear_s_val = 3'b000;
        chk("ws_done", 32'(stage_done), 32'd2);
        tick();

        s_done    = n_done;
        s_err     = n_err;
        stage_val = 3'b010;
        tick();
        stage_val = 3'b000;
        tick();
        repeat (19) tick();
        chk("to_err_early", 32'(stage_err), 32'd0);
        chk("to_mode_busy", 32'(rsa_mode), 32'd2);
        tick();
        chk("to_err", 32'(stage_err), 32'd1);
        chk("to_mode", 32'(rsa_mode), 32'd0);
        chk("to_rdy", 32'(stage_rdy), 32'd7);
        tick();
        chk("to_err_low", 32'(stage_err), 32'd0);
        chk("to_mode_after", 32'(rsa_mode), 32'd0);
        chk("to_rdy_after", 32'(stage_rdy), 32'd7);
        chk("to_ndone", 32'(n_done - s_done), 32'd0);
        chk("to_nerr", 32'(n_err - s_err), 32'd1);

        s_done          = n_done;
        s_err           = n_err;
        landmark_num    = 10'd6;
        rsa_done        = 1'b1;
        nonlinear_s_val = 3'b100;
        stage_val       = 3'b100;
        tick();
        stage_val = 3'b000;
        for (int p = 0; p < 3; p++) begin
            wait_mval($sformatf("rst_mval%0d", p));
            nonlinear_s_rdy = 3'b100;
            tick();
            nonlinear_s_rdy = 3'b000;
        end
        wait_mval("rst_mval3");
        chk("rst_idx3", 32'(seq_idx), 32'd3);
        sys_rst = 1'b1;
        tick();
        chk_reset_outputs("rst_mid");
        tick();
        sys_rst = 1'b0;
        idle_inputs();
        chk("rst_ndone", 32'(n_done - s_done), 32'd0);
        chk("rst_nerr", 32'(n_err - s_err), 32'd0);
        tick();
        run_prd_0wait("prd_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
